// File: rtl/radar_cmd_sched.sv
// Radar command frame scheduler: two request slots plus a periodic poll,
// round-robin arbitration, and MSB-byte-first serialization into a UART TX handshake.
module radar_cmd_sched #(
  parameter int unsigned POLL_CYCLES = 50000000,
  parameter logic [47:0] POLL_FRAME  = 48'h555A02D38400,
  parameter logic [2:0]  POLL_LEN    = 3'd5
) (
  input  logic        Clk,
  input  logic        RstN,
  input  logic        ReqA_En,
  input  logic [47:0] ReqA_Data,
  input  logic [2:0]  ReqA_Len,
  input  logic        ReqB_En,
  input  logic [47:0] ReqB_Data,
  input  logic [2:0]  ReqB_Len,
  input  logic        PollEn,
  input  logic        TxBusy,
  output logic        TxStart,
  output logic [7:0]  TxData,
  output logic        Busy,
  output logic        FrameDone,
  output logic [1:0]  FrameSrc,
  output logic        OvfA,
  output logic        OvfB,
  output logic        ErrLen
);

  localparam int unsigned PollW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [PollW-1:0] PollLast = PollW'(POLL_CYCLES - 1);

  typedef enum logic [1:0] {Idle, Send, Ack, Drain} stateT;

  stateT             state, stateNxt;
  logic              slotAFull, slotAFullNxt, slotBFull, slotBFullNxt;
  logic [47:0]       slotAData, slotADataNxt, slotBData, slotBDataNxt;
  logic [2:0]        slotALen, slotALenNxt, slotBLen, slotBLenNxt;
  logic [PollW-1:0]  pollCnt, pollCntNxt;
  logic              pollPend, pollPendNxt;
  logic              rrPtrB, rrPtrBNxt;
  logic [47:0]       shiftReg, shiftNxt;
  logic [2:0]        byteCnt, cntNxt;
  logic              txStartNxt, busyNxt, doneNxt, ovfANxt, ovfBNxt, errNxt;
  logic [7:0]        txDataNxt;
  logic [1:0]        srcNxt;
  logic              grantA, grantB, grantP;
  logic              lenAOk, lenBOk, acceptA, acceptB;

  // Next-state, datapath and registered-output logic
  always_comb begin
    stateNxt     = state;
    shiftNxt     = shiftReg;
    cntNxt       = byteCnt;
    txStartNxt   = 1'b0;
    txDataNxt    = TxData;
    busyNxt      = Busy;
    doneNxt      = 1'b0;
    srcNxt       = FrameSrc;
    rrPtrBNxt    = rrPtrB;
    grantA       = 1'b0;
    grantB       = 1'b0;
    grantP       = 1'b0;

    case (state)
      Idle: begin
        if (slotAFull && slotBFull) begin
          grantA    = ~rrPtrB;
          grantB    = rrPtrB;
          rrPtrBNxt = ~rrPtrB;
        end else if (slotAFull) begin
          grantA = 1'b1;
        end else if (slotBFull) begin
          grantB = 1'b1;
        end else if (pollPend) begin
          grantP = 1'b1;
        end
        if (grantA) begin
          shiftNxt = slotAData;
          cntNxt   = slotALen;
          srcNxt   = 2'b01;
        end else if (grantB) begin
          shiftNxt = slotBData;
          cntNxt   = slotBLen;
          srcNxt   = 2'b10;
        end else if (grantP) begin
          shiftNxt = POLL_FRAME;
          cntNxt   = POLL_LEN;
          srcNxt   = 2'b11;
        end
        if (grantA || grantB || grantP) begin
          busyNxt  = 1'b1;
          stateNxt = Send;
        end
      end
      Send: begin
        if (!TxBusy) begin
          txStartNxt = 1'b1;
          txDataNxt  = shiftReg[47:40];
          shiftNxt   = {shiftReg[39:0], 8'h00};
          cntNxt     = byteCnt - 3'd1;
          stateNxt   = Ack;
        end
      end
      Ack: begin
        if (TxBusy) stateNxt = Drain;
      end
      Drain: begin
        if (!TxBusy) begin
          if (byteCnt != 3'd0) begin
            stateNxt = Send;
          end else begin
            doneNxt  = 1'b1;
            busyNxt  = 1'b0;
            stateNxt = Idle;
          end
        end
      end
      default: stateNxt = Idle;
    endcase

    // A slot granted this cycle counts as empty, so a same-cycle request refills it
    lenAOk       = (ReqA_Len != 3'd0) && (ReqA_Len != 3'd7);
    lenBOk       = (ReqB_Len != 3'd0) && (ReqB_Len != 3'd7);
    acceptA      = ReqA_En && lenAOk && (!slotAFull || grantA);
    acceptB      = ReqB_En && lenBOk && (!slotBFull || grantB);
    slotAFullNxt = acceptA ? 1'b1 : (grantA ? 1'b0 : slotAFull);
    slotBFullNxt = acceptB ? 1'b1 : (grantB ? 1'b0 : slotBFull);
    slotADataNxt = acceptA ? ReqA_Data : slotAData;
    slotBDataNxt = acceptB ? ReqB_Data : slotBData;
    slotALenNxt  = acceptA ? ReqA_Len : slotALen;
    slotBLenNxt  = acceptB ? ReqB_Len : slotBLen;
    ovfANxt      = ReqA_En && lenAOk && slotAFull && !grantA;
    ovfBNxt      = ReqB_En && lenBOk && slotBFull && !grantB;
    errNxt       = (ReqA_En && !lenAOk) || (ReqB_En && !lenBOk);

    if (!PollEn) begin
      pollCntNxt  = '0;
      pollPendNxt = 1'b0;
    end else if (pollCnt == PollLast) begin
      pollCntNxt  = '0;
      pollPendNxt = 1'b1;
    end else begin
      pollCntNxt  = pollCnt + PollW'(1);
      pollPendNxt = pollPend && !grantP;
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state     <= Idle;
      slotAFull <= 1'b0;
      slotBFull <= 1'b0;
      slotAData <= '0;
      slotBData <= '0;
      slotALen  <= '0;
      slotBLen  <= '0;
      pollCnt   <= '0;
      pollPend  <= 1'b0;
      rrPtrB    <= 1'b0;
      shiftReg  <= '0;
      byteCnt   <= '0;
      TxStart   <= 1'b0;
      TxData    <= '0;
      Busy      <= 1'b0;
      FrameDone <= 1'b0;
      FrameSrc  <= '0;
      OvfA      <= 1'b0;
      OvfB      <= 1'b0;
      ErrLen    <= 1'b0;
    end else begin
      state     <= stateNxt;
      slotAFull <= slotAFullNxt;
      slotBFull <= slotBFullNxt;
      slotAData <= slotADataNxt;
      slotBData <= slotBDataNxt;
      slotALen  <= slotALenNxt;
      slotBLen  <= slotBLenNxt;
      pollCnt   <= pollCntNxt;
      pollPend  <= pollPendNxt;
      rrPtrB    <= rrPtrBNxt;
      shiftReg  <= shiftNxt;
      byteCnt   <= cntNxt;
      TxStart   <= txStartNxt;
      TxData    <= txDataNxt;
      Busy      <= busyNxt;
      FrameDone <= doneNxt;
      FrameSrc  <= srcNxt;
      OvfA      <= ovfANxt;
      OvfB      <= ovfBNxt;
      ErrLen    <= errNxt;
    end
  end

endmodule

// File: doc/radar_cmd_sched.md
Name: radar_cmd_sched

Overview:
Command frame scheduler between the radar command sources and the byte-wide UART transmitter. It accepts up to 6-byte command frames from two requesters (A: key controller, B: host/aux logic) and from an internal periodic poll timer. It arbitrates between them and serializes the granted frame MSB-byte-first into the UART TX start/busy handshake. It reports completion, source and overflow/error events to the surrounding control logic.

Parameters:
POLL_CYCLES, 50000000, poll interval in Clk cycles (1 s at 50 MHz)
POLL_FRAME, 48'h555A02D38400, left-justified query frame sent by the poll timer
POLL_LEN, 3'd5, byte count of POLL_FRAME

Ports:
Clk  input  1  system clock; all logic on rising edge
RstN  input  1  reset, asynchronous, active-low
ReqA_En  input  1  one-cycle frame request, requester A
ReqA_Data  input  48  frame A, left-justified (byte0 = [47:40])
ReqA_Len  input  3  frame A byte count, legal 1..6
ReqB_En  input  1  one-cycle frame request, requester B
ReqB_Data  input  48  frame B, left-justified
ReqB_Len  input  3  frame B byte count, legal 1..6
PollEn  input  1  level; enables the periodic poll timer
TxBusy  input  1  UART transmitter busy
TxStart  output  1  one-cycle byte start pulse to UART
TxData  output  8  byte to send; valid while TxStart=1
Busy  output  1  high from grant until frame done
FrameDone  output  1  one-cycle pulse after last byte finishes
FrameSrc  output  2  source of current/last frame: 01=A, 10=B, 11=poll
OvfA  output  1  one-cycle pulse: ReqA_En dropped (slot A full)
OvfB  output  1  one-cycle pulse: ReqB_En dropped (slot B full)
ErrLen  output  1  one-cycle pulse: request with Len 0 or 7 rejected

Behaviour:
- Reset (RstN low, async): all outputs 0, slots empty, poll counter 0, poll pending 0, round-robin pointer = A, FSM IDLE. A reset mid-frame aborts immediately; no partial-frame completion after release.
- Slots: one holding register per requester (data, len, full flag). ReqX_En with a legal Len and an empty slot: store, full=1 after that edge. Slot full: request dropped, old content kept, OvfX pulse the next cycle. Illegal Len: not stored, ErrLen pulse the next cycle (A and B illegal in the same cycle: one ErrLen pulse). A slot is freed on its grant edge, so a new request in the grant cycle is accepted.
- Poll timer: counts while PollEn=1; at count POLL_CYCLES-1 it wraps to 0 and sets poll pending. PollEn=0 clears the counter and poll pending. Poll pending clears on grant.
- Arbitration (IDLE only): A and B both full -> grant the one not granted last; then toggle pointer. Exactly one full -> grant it. Poll is granted only when both slots are empty. Grant: load 48-bit shift reg and byte counter, set FrameSrc and Busy, go to SEND.
- FSM: IDLE -> SEND (on grant).
  - SEND: if TxBusy=0, register TxStart=1 and TxData=shift[47:40], shift left 8, decrement count, go to ACK. Otherwise hold.
  - ACK: wait for TxBusy=1, then go to DRAIN.
  - DRAIN: wait for TxBusy=0. If count>0, go to SEND. Otherwise pulse FrameDone, clear Busy, go to IDLE.
- Latency: ReqA_En high in cycle 0 with FSM idle and TxBusy low -> TxStart high in cycle 3. Next byte's TxStart is high 2 cycles after the first cycle TxBusy is sampled low in DRAIN.
- FrameSrc holds its value after FrameDone until the next grant.
- Simultaneous ReqA_En, ReqB_En and poll wrap: all three are captured. Grant order follows the round-robin pointer; poll goes last.

Test Plan:
- Single A frame: ReqA_Data=48'h555A02D38400, Len=5; UART model raises busy 1 cycle after start for 10 cycles -> TxData sequence 55,5A,02,D3,84; first TxStart in cycle 3; FrameDone once; FrameSrc=01.
- Round-robin: A (6 bytes 555A03D10184) and B (Len=1, 0xAA) requested in the same cycle, pointer=A -> A frame then B frame; a repeated A+B pair -> B first.
- Overflow: ReqA_En twice while A is pending behind a B frame in progress -> one OvfA pulse; only the first A frame is transmitted.
- Length error: ReqB_Len=0, then 7 -> two ErrLen pulses, no TxStart, slot B stays empty.
- Poll: POLL_CYCLES=20, PollEn=1 -> POLL_FRAME sent every 20 cycles while idle. An A request pending at the poll wrap -> A sent first, then poll with FrameSrc=11. PollEn=0 -> no further polls.
- Reset mid-frame: RstN low during the 3rd byte -> all outputs 0 immediately; after release no TxStart until a new request arrives.
